cpu_bus_sequencer: RTL and testbench
====================================

CPU_BUS_SEQUENCER -- requirements
Module: cpu_bus_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16: bus and channel address width.
REQ-002 Parameter NUM_CH, default 2: number of requesting channels; channel 0 has highest priority.
REQ-003 Parameter MAX_BYTES, default 4: maximum bytes per transaction; LW = clog2(MAX_BYTES).
REQ-004 Parameter TIMEOUT, default 255: maximum cycles to wait for rd_ack per byte; 0 disables the timeout.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 ch_req  in  NUM_CH  per-channel level request; held until the matching ch_ack.
REQ-008 ch_we  in  NUM_CH  per-channel direction: 1 = write, 0 = read.
REQ-009 ch_addr  in  NUM_CH*ADDR_W  per-channel start address.
REQ-010 ch_len  in  NUM_CH*LW  per-channel byte count minus 1.
REQ-011 ch_wdata  in  NUM_CH*8*MAX_BYTES  per-channel write data, little-endian (byte 0 = bits 7:0).
REQ-012 ch_ack  out  NUM_CH  one-cycle completion pulse for the granted channel.
REQ-013 ch_err  out  1  valid with ch_ack; 1 = at least one read byte timed out.
REQ-014 rdata  out  8*MAX_BYTES  assembled read data, little-endian.
REQ-015 bus_addr  out  ADDR_W  external bus address.
REQ-016 bus_rd_req  out  1  external read request.
REQ-017 bus_rd_ack  in  1  external read acknowledge; bus_rd_data valid in the same cycle.
REQ-018 bus_rd_data  in  8  external read data.
REQ-019 bus_wr_data  out  8  external write data.
REQ-020 bus_wr_enable  out  1  external write strobe; one cycle per byte.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 States: IDLE, RD_ISSUE, RD_WAIT, RD_GAP, WR, DONE.
REQ-023 IDLE: on an edge with any ch_req high, grant the lowest-index requester.
  - Latch that channel's we, addr, len and wdata.
  - Clear the byte index i and the err flag.
  - Go to WR if we = 1, else to RD_ISSUE.
REQ-024 Requests arriving while not IDLE are ignored until the next IDLE.
  - Deasserting the granted ch_req mid-transfer does not abort the transfer; ch_ack is still pulsed.
REQ-025 Byte address = latched addr + i, computed modulo 2^ADDR_W; 16'hFFFF + 1 wraps to 16'h0000.
REQ-026 WR: each cycle drive bus_addr = addr+i, bus_wr_data = wdata byte i, bus_wr_enable = 1.
  - Increment i; after byte len, go to DONE.
  - Bytes go out on consecutive cycles with no gaps.
REQ-027 RD_ISSUE: drive bus_addr = addr+i and bus_rd_req = 1, then go to RD_WAIT.
REQ-028 RD_WAIT: hold bus_rd_req = 1 and count wait cycles.
  - On an edge with bus_rd_ack = 1: store bus_rd_data into rdata byte i and drop bus_rd_req.
  - Then go to DONE if i = len, else increment i and go to RD_GAP.
REQ-029 Read timeout: when TIMEOUT != 0 and the wait count reaches TIMEOUT without bus_rd_ack:
  - store 8'hFF into byte i, set err, drop bus_rd_req, and continue as if acked.
  - A bus_rd_ack in the same edge as the timeout has priority; the byte is not an error.
REQ-030 RD_GAP: bus_rd_req = 0 for exactly one cycle, then go to RD_ISSUE.
REQ-031 On read grant, clear rdata bytes above len to 0; rdata holds its value until the next read grant.
REQ-032 DONE: ch_ack[grant] = 1 and ch_err = err for exactly one cycle, then go to IDLE.
  - A requester that still holds ch_req in the IDLE cycle after ack is re-serviced.
REQ-033 Latency:
  - N-byte write: wr_enable in cycles 1..N after the grant edge; ack in cycle N+1.
  - Read with zero-wait ack (ack in the first RD_WAIT cycle): 3N cycles from grant to ack.
REQ-034 bus_wr_enable and bus_rd_req are never high in the same cycle.
REQ-035 bus_addr holds its last value in IDLE; bus_wr_data is don't-care while bus_wr_enable = 0.

Reset
REQ-036 While reset_n = 0 at an edge:
  - state = IDLE; ch_ack = 0; ch_err = 0; bus_rd_req = 0; bus_wr_enable = 0; busy = 0.
  - bus_addr = 0; bus_wr_data = 0; rdata = 0; grant and counters cleared.
REQ-037 Reset mid-transaction aborts it immediately; no ch_ack is issued for the aborted transfer.
REQ-038 The first grant is possible on the first edge with reset_n = 1.

Verification
REQ-039 Ch1 read, len=1, addr 16'h0444, memory 34 12, ack after 2 wait cycles:
  -> bus_rd_req at 0444 then 0445 with a 1-cycle gap; ch_ack[1] once; rdata = 32'h00001234; ch_err = 0.
REQ-040 Ch0 write, len=3, addr 16'hFFFE, wdata 32'hDDCCBBAA:
  -> wr_enable on 4 consecutive cycles, addr/data FFFE/AA, FFFF/BB, 0000/CC, 0001/DD; ch_ack[0] in cycle 5.
REQ-041 Ch0 and ch1 both raise req on the same edge:
  -> ch0 is served first; ch1 is granted on the IDLE cycle after ch0's ack; exactly one ack each.
REQ-042 TIMEOUT = 4, read len=1, memory never acks byte 1:
  -> byte 1 = FF after 4 wait cycles; ch_err = 1 with ack; byte 0 is correct.
REQ-043 reset_n low for one cycle during RD_WAIT of a 4-byte read:
  -> bus_rd_req = 0, busy = 0, rdata = 0, no ch_ack; a new request afterwards completes normally.

Source files
------------

// File: rtl/cpu_bus_sequencer.sv
// Multi-channel byte sequencer: arbitrates channel requests (channel 0 highest priority)
// and runs each granted transfer byte-by-byte on a simple external read/write bus.
module cpu_bus_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int MAX_BYTES = 4,
    parameter int TIMEOUT   = 255,
    localparam int LW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH*LW-1:0]      ch_len,
    input  logic [NUM_CH*8*MAX_BYTES-1:0] ch_wdata,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic                      ch_err,
    output logic [8*MAX_BYTES-1:0]    rdata,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic                      bus_rd_req,
    input  logic                      bus_rd_ack,
    input  logic [7:0]                bus_rd_data,
    output logic [7:0]                bus_wr_data,
    output logic                      bus_wr_enable,
    output logic                      busy
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_GAP,
        WR,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [GW-1:0]          grant_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [LW-1:0]          len_q;
    logic [8*MAX_BYTES-1:0] wdata_q;
    logic [LW-1:0]          idx_q;
    logic [WW-1:0]          wait_q;
    logic                   err_q;
    logic [8*MAX_BYTES-1:0] rdata_q;

    logic                   req_any;
    logic [GW-1:0]          sel_idx;
    logic                   sel_we;
    logic [ADDR_W-1:0]      sel_addr;
    logic [LW-1:0]          sel_len;
    logic [8*MAX_BYTES-1:0] sel_wdata;
    logic                   last_byte;
    logic                   timed_out;
    logic                   rd_done;

    // Fixed-priority pick: the first requester found from index 0 upward wins.
    always_comb begin
        req_any   = 1'b0;
        sel_idx   = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_req[c] && !req_any) begin
                req_any   = 1'b1;
                sel_idx   = GW'(c);
                sel_we    = ch_we[c];
                sel_addr  = ch_addr[c*ADDR_W +: ADDR_W];
                sel_len   = ch_len[c*LW +: LW];
                sel_wdata = ch_wdata[c*8*MAX_BYTES +: 8*MAX_BYTES];
            end
        end
    end

    // An ack on the same edge as the timeout wins, so timed_out excludes bus_rd_ack.
    always_comb begin
        last_byte = (idx_q == len_q);
        timed_out = (TIMEOUT != 0) && !bus_rd_ack && (wait_q == WAIT_LAST);
        rd_done   = bus_rd_ack || timed_out;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_any) state_d = sel_we ? WR : RD_ISSUE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  if (rd_done) state_d = last_byte ? DONE : RD_GAP;
            RD_GAP:   state_d = RD_ISSUE;
            WR:       if (last_byte) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // The byte index stops at len so bus_addr keeps showing the last byte's address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        grant_q <= sel_idx;
                        addr_q  <= sel_addr;
                        len_q   <= sel_len;
                        wdata_q <= sel_wdata;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        if (!sel_we) begin
                            for (int unsigned b = 0; b < MAX_BYTES; b++) begin
                                if (b > 32'(sel_len)) rdata_q[b*8 +: 8] <= '0;
                            end
                        end
                    end
                end
                RD_ISSUE: wait_q <= '0;
                RD_WAIT: begin
                    if (rd_done) begin
                        rdata_q[{idx_q, 3'b000} +: 8] <= bus_rd_ack ? bus_rd_data : 8'hFF;
                        if (!bus_rd_ack) err_q <= 1'b1;
                        if (!last_byte) idx_q <= idx_q + 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                WR: if (!last_byte) idx_q <= idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ch_ack = '0;
        if (state_q == DONE) ch_ack[grant_q] = 1'b1;
        ch_err        = (state_q == DONE) && err_q;
        busy          = (state_q != IDLE);
        bus_rd_req    = (state_q == RD_ISSUE) || (state_q == RD_WAIT);
        bus_wr_enable = (state_q == WR);
        bus_wr_data   = (state_q == WR) ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
        bus_addr      = addr_q + ADDR_W'(idx_q);
        rdata         = rdata_q;
    end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Self-checking bench for cpu_bus_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level model of bus timing and results.
module tb_cpu_bus_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  ch_req = '0;
    logic [1:0]  ch_we = '0;
    logic [31:0] ch_addr = '0;
    logic [3:0]  ch_len = '0;
    logic [63:0] ch_wdata = '0;
    logic [1:0]  ch_ack;
    logic        ch_err;
    logic [31:0] rdata;
    logic [15:0] bus_addr;
    logic        bus_rd_req;
    logic        bus_rd_ack;
    logic [7:0]  bus_rd_data;
    logic [7:0]  bus_wr_data;
    logic        bus_wr_enable;
    logic        busy;

    cpu_bus_sequencer #(.ADDR_W(16), .NUM_CH(2), .MAX_BYTES(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_len(ch_len), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_err(ch_err), .rdata(rdata),
        .bus_addr(bus_addr), .bus_rd_req(bus_rd_req), .bus_rd_ack(bus_rd_ack),
        .bus_rd_data(bus_rd_data), .bus_wr_data(bus_wr_data), .bus_wr_enable(bus_wr_enable),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int cyc; logic [15:0] addr; logic [7:0] data; } ev_t;
    typedef struct { int cyc; logic [1:0] ack; logic err; logic [31:0] rdata; } ack_t;

    ev_t  ev_q[$];
    ack_t ack_q[$];
    ev_t  exp_ev[$];
    int   exp_ack_off;
    logic exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] last_rdata = '0;
    logic [7:0]  mem_ovr [logic [15:0]];
    int   dly[4] = '{0, 0, 0, 0};
    int   rd_byte = 0, req_cyc = 0, cur_dly = 0, overlap = 0, cyc = 0;
    int   total = 0, bad = 0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Bus monitor and memory responder: ack arrives after dly[byte] wait cycles.
    initial begin
        bus_rd_ack  = 1'b0;
        bus_rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_wr_enable) ev_q.push_back('{1'b1, cyc, bus_addr, bus_wr_data});
            if (bus_wr_enable && bus_rd_req) overlap++;
            if (ch_ack != 2'b00) ack_q.push_back('{cyc, ch_ack, ch_err, rdata});
            if (bus_rd_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    ev_q.push_back('{1'b0, cyc, bus_addr, 8'h00});
                    cur_dly = (rd_byte < 4) ? dly[rd_byte] : 0;
                    rd_byte++;
                end
                bus_rd_ack  = (req_cyc == cur_dly + 2);
                bus_rd_data = bus_rd_ack ? mem_byte(bus_addr) : 8'($urandom);
            end else begin
                req_cyc     = 0;
                bus_rd_ack  = 1'b0;
                bus_rd_data = 8'($urandom);
            end
        end
    end

    // Transaction-level expectation: event offsets are cycles after the request is raised.
    task automatic model_txn(input bit we, input logic [15:0] addr, input int len,
                             input logic [31:0] wdata);
        int off;
        int w;
        exp_ev.delete();
        exp_err = 1'b0;
        if (we) begin
            for (int j = 0; j <= len; j++) exp_ev.push_back('{1'b1, 1 + j, addr + 16'(j), wdata[8*j +: 8]});
            exp_ack_off = len + 2;
            exp_rdata   = last_rdata;
        end else begin
            off = 1;
            exp_rdata = '0;
            for (int j = 0; j <= len; j++) begin
                exp_ev.push_back('{1'b0, off, addr + 16'(j), 8'h00});
                if (dly[j] < TO) begin
                    w = dly[j] + 1;
                    exp_rdata[8*j +: 8] = mem_byte(addr + 16'(j));
                end else begin
                    w = TO;
                    exp_rdata[8*j +: 8] = 8'hFF;
                    exp_err = 1'b1;
                end
                off += 2 + w;
            end
            exp_ack_off = off - 1;
            last_rdata  = exp_rdata;
        end
    endtask

    task automatic issue(input int ch, input bit we, input logic [15:0] addr, input int len,
                         input logic [31:0] wdata);
        ch_we[ch]             = we;
        ch_addr[ch*16 +: 16]  = addr;
        ch_len[ch*2 +: 2]     = 2'(len);
        ch_wdata[ch*32 +: 32] = wdata;
        ch_req[ch]            = 1'b1;
    endtask

    task automatic wait_ack(input int ch, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (ch_ack[ch]) begin
                ok = 1'b1;
                ch_req[ch] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int start;
        repeat (3) @(negedge clk);
        total++;
        if ({ch_ack, ch_err, bus_rd_req, bus_wr_enable, busy} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000", {ch_ack, ch_err, bus_rd_req, bus_wr_enable, busy});
        end
        total++;
        if ({bus_addr, bus_wr_data, rdata} !== 56'h0) begin
            bad++; $display("FAIL reset_data got addr=%h wd=%h rdata=%h want all zero", bus_addr, bus_wr_data, rdata);
        end
        ev_q.delete(); ack_q.delete();
        reset_n = 1'b1;
        start = cyc;
        issue(0, 1'b1, 16'h0ABC, 0, 32'h0000_0077);
        wait_ack(0, 20, ok);
        @(negedge clk);
        total++;
        if (!ok || ack_q.size() != 1 || ack_q[0].cyc - start != 2) begin
            bad++; $display("FAIL first_grant ok=%0d acks=%0d want ack at offset 2", ok, ack_q.size());
        end
        total++;
        if (ev_q.size() != 1 || ev_q[0].cyc - start != 1 || ev_q[0].addr !== 16'h0ABC || ev_q[0].data !== 8'h77) begin
            bad++; $display("FAIL first_grant_bus events=%0d want one write 0ABC/77 at offset 1", ev_q.size());
        end
    endtask

    task automatic test_read_example();
        bit ok;
        int start;
        mem_ovr[16'h0444] = 8'h34;
        mem_ovr[16'h0445] = 8'h12;
        dly = '{2, 2, 0, 0};
        @(negedge clk);
        ev_q.delete(); ack_q.delete(); rd_byte = 0;
        start = cyc;
        issue(1, 1'b0, 16'h0444, 1, 32'h0);
        wait_ack(1, 50, ok);
        @(negedge clk);
        last_rdata = 32'h0000_1234;
        total++;
        if (!ok || ack_q.size() != 1) begin
            bad++; $display("FAIL rd_ex_ack ok=%0d acks=%0d want 1", ok, ack_q.size());
        end else begin
            total++;
            if (ack_q[0].ack !== 2'b10 || ack_q[0].err !== 1'b0 || ack_q[0].rdata !== 32'h0000_1234 || ack_q[0].cyc - start != 10) begin
                bad++; $display("FAIL rd_ex_result ack=%b err=%b rdata=%h off=%0d want 10/0/00001234/10",
                                ack_q[0].ack, ack_q[0].err, ack_q[0].rdata, ack_q[0].cyc - start);
            end
        end
        total++;
        if (ev_q.size() != 2 || ev_q[0].wr || ev_q[1].wr || ev_q[0].addr !== 16'h0444 || ev_q[1].addr !== 16'h0445 ||
            ev_q[0].cyc - start != 1 || ev_q[1].cyc - start != 6) begin
            bad++; $display("FAIL rd_ex_bus events=%0d want rd 0444@1 and 0445@6", ev_q.size());
        end
    endtask

    task automatic test_write_wrap();
        bit ok;
        int start;
        logic [15:0] ea[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        logic [7:0]  ed[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        ev_q.delete(); ack_q.delete();
        start = cyc;
        issue(0, 1'b1, 16'hFFFE, 3, 32'hDDCC_BBAA);
        wait_ack(0, 20, ok);
        @(negedge clk);
        total++;
        if (!ok || ack_q.size() != 1 || ack_q[0].cyc - start != 5 || ack_q[0].ack !== 2'b01) begin
            bad++; $display("FAIL wr_wrap_ack ok=%0d acks=%0d want ch0 ack at offset 5", ok, ack_q.size());
        end
        total++;
        if (ev_q.size() != 4) begin
            bad++; $display("FAIL wr_wrap_count got=%0d want=4", ev_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (!ev_q[j].wr || ev_q[j].addr !== ea[j] || ev_q[j].data !== ed[j] || ev_q[j].cyc - start != j + 1) begin
                    bad++; $display("FAIL wr_wrap_byte%0d got=%h/%h@%0d want=%h/%h@%0d", j, ev_q[j].addr,
                                    ev_q[j].data, ev_q[j].cyc - start, ea[j], ed[j], j + 1);
                end
            end
        end
    endtask

    task automatic test_priority();
        int start, n0, n1, t0, t1;
        @(negedge clk);
        ev_q.delete(); ack_q.delete();
        n0 = 0; n1 = 0; t0 = -1; t1 = -1;
        start = cyc;
        issue(0, 1'b1, 16'h0100, 1, 32'h0000_2211);
        issue(1, 1'b1, 16'h0200, 0, 32'h0000_0033);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ch_ack[0]) begin n0++; t0 = cyc - start; ch_req[0] = 1'b0; end
            if (ch_ack[1]) begin n1++; t1 = cyc - start; ch_req[1] = 1'b0; end
        end
        total++;
        if (n0 != 1 || n1 != 1 || t0 != 3 || t1 != 6) begin
            bad++; $display("FAIL priority n0=%0d t0=%0d n1=%0d t1=%0d want 1/3 1/6", n0, t0, n1, t1);
        end
        total++;
        if (ev_q.size() != 3 || ev_q[2].addr !== 16'h0200 || ev_q[2].data !== 8'h33 || ev_q[2].cyc - start != 5) begin
            bad++; $display("FAIL priority_bus events=%0d want ch1 write 0200/33 at offset 5", ev_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int start, n, t1, t2;
        @(negedge clk);
        ev_q.delete(); ack_q.delete();
        n = 0; t1 = -1; t2 = -1;
        start = cyc;
        issue(1, 1'b1, 16'h0300, 0, 32'h0000_0044);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ch_ack[1]) begin
                n++;
                if (n == 1) t1 = cyc - start;
                else begin t2 = cyc - start; ch_req[1] = 1'b0; end
            end
        end
        total++;
        if (n != 2 || t1 != 2 || t2 != 5) begin
            bad++; $display("FAIL back_to_back acks=%0d t1=%0d t2=%0d want 2 acks at 2 and 5", n, t1, t2);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int start;
        logic [15:0] ta[3]  = '{16'h1230, 16'h1240, 16'h1250};
        int          tl[3]  = '{1, 0, 0};
        int          td0[3] = '{0, 3, 4};
        int          toff[3] = '{9, 6, 6};
        logic        terr[3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] trd[3] = '{32'h0000_FF5E, 32'h0000_009C, 32'h0000_00FF};
        mem_ovr[16'h1230] = 8'h5E;
        mem_ovr[16'h1240] = 8'h9C;
        mem_ovr[16'h1250] = 8'h11;
        for (int t = 0; t < 3; t++) begin
            dly = '{td0[t], 255, 255, 255};
            @(negedge clk);
            ev_q.delete(); ack_q.delete(); rd_byte = 0;
            start = cyc;
            issue(t % 2, 1'b0, ta[t], tl[t], 32'h0);
            wait_ack(t % 2, 60, ok);
            @(negedge clk);
            total++;
            if (!ok || ack_q.size() != 1) begin
                bad++; $display("FAIL timeout%0d_ack ok=%0d acks=%0d want 1", t, ok, ack_q.size());
            end else begin
                total++;
                if (ack_q[0].err !== terr[t] || ack_q[0].rdata !== trd[t] || ack_q[0].cyc - start != toff[t]) begin
                    bad++; $display("FAIL timeout%0d_result err=%b rdata=%h off=%0d want %b/%h/%0d", t,
                                    ack_q[0].err, ack_q[0].rdata, ack_q[0].cyc - start, terr[t], trd[t], toff[t]);
                end
            end
            last_rdata = trd[t];
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int start;
        dly = '{0, 255, 255, 255};
        @(negedge clk);
        ev_q.delete(); ack_q.delete(); rd_byte = 0;
        issue(0, 1'b0, 16'h2000, 3, 32'h0);
        repeat (6) @(negedge clk);
        total++;
        if (bus_rd_req !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_pre rd_req=%b busy=%b want 1/1", bus_rd_req, busy);
        end
        reset_n = 1'b0;
        ch_req  = 2'b00;
        @(negedge clk);
        total++;
        if (bus_rd_req !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0 || ch_ack !== 2'b00) begin
            bad++; $display("FAIL rst_mid_state rd_req=%b busy=%b rdata=%h ack=%b want 0/0/0/00",
                            bus_rd_req, busy, rdata, ch_ack);
        end
        reset_n = 1'b1;
        last_rdata = '0;
        repeat (8) @(negedge clk);
        total++;
        if (ack_q.size() != 0) begin
            bad++; $display("FAIL rst_mid_noack got=%0d want=0", ack_q.size());
        end
        dly = '{0, 0, 0, 0};
        ev_q.delete(); ack_q.delete(); rd_byte = 0;
        start = cyc;
        issue(1, 1'b0, 16'h2000, 1, 32'h0);
        wait_ack(1, 40, ok);
        @(negedge clk);
        total++;
        if (!ok || ack_q.size() != 1 || ack_q[0].cyc - start != 6 || ack_q[0].err !== 1'b0 ||
            ack_q[0].rdata !== {16'h0, mem_byte(16'h2001), mem_byte(16'h2000)}) begin
            bad++; $display("FAIL rst_mid_after ok=%0d acks=%0d want clean 2-byte read acked at offset 6", ok, ack_q.size());
        end
        last_rdata = {16'h0, mem_byte(16'h2001), mem_byte(16'h2000)};
    endtask

    task automatic test_random();
        bit ok, we, diff;
        int ch, len, start;
        logic [15:0] addr;
        logic [31:0] wdata;
        for (int t = 0; t < 40; t++) begin
            ch = $urandom_range(0, 1); we = 1'($urandom_range(0, 1));
            addr = 16'($urandom); len = $urandom_range(0, 3); wdata = $urandom;
            for (int k = 0; k < 4; k++) dly[k] = $urandom_range(0, 5);
            @(negedge clk);
            ev_q.delete(); ack_q.delete(); rd_byte = 0;
            start = cyc;
            issue(ch, we, addr, len, wdata);
            model_txn(we, addr, len, wdata);
            wait_ack(ch, 200, ok);
            @(negedge clk);
            total++;
            if (!ok || ack_q.size() != 1) begin
                bad++; $display("FAIL rand%0d_ack ok=%0d acks=%0d want 1", t, ok, ack_q.size());
            end else begin
                total++;
                if (ack_q[0].ack !== 2'(1 << ch) || ack_q[0].cyc - start != exp_ack_off ||
                    ack_q[0].err !== exp_err || ack_q[0].rdata !== exp_rdata) begin
                    bad++; $display("FAIL rand%0d_result ack=%b off=%0d err=%b rdata=%h want %b/%0d/%b/%h", t,
                                    ack_q[0].ack, ack_q[0].cyc - start, ack_q[0].err, ack_q[0].rdata,
                                    2'(1 << ch), exp_ack_off, exp_err, exp_rdata);
                end
            end
            diff = (ev_q.size() != exp_ev.size());
            for (int j = 0; j < ev_q.size() && !diff; j++) begin
                if (ev_q[j].wr != exp_ev[j].wr || ev_q[j].cyc - start != exp_ev[j].cyc ||
                    ev_q[j].addr !== exp_ev[j].addr || (exp_ev[j].wr && ev_q[j].data !== exp_ev[j].data)) diff = 1'b1;
            end
            total++;
            if (diff) begin
                bad++; $display("FAIL rand%0d_bus we=%0d addr=%h len=%0d events got=%0d want=%0d", t, we, addr, len,
                                ev_q.size(), exp_ev.size());
            end
        end
        total++;
        if (overlap != 0) begin
            bad++; $display("FAIL rd_wr_overlap got=%0d want=0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_read_example();
        test_write_wrap();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
